// File: rtl/regfile_mp.sv
// Multi-port CPU register file: NREAD read ports, two write ports,
// optional write bypass, hardwired zero register and sequential clear.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [XLEN-1:0]       wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd1,
  input  logic                  clear_req,
  output logic                  ready,
  output logic                  wr_conflict
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            conflict_q, conflict_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  logic wr0, wr1, same_addr;

  // Address 0 is a sink when hardwired to zero.
  assign wr0 = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign wr1 = we1 && !(ZERO_REG != 0 && wa1 == '0);
  assign same_addr = (wa0 == wa1);

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    conflict_d = 1'b0;
    mem_d      = mem_q;
    unique case (state_q)
      CLEAR: begin
        mem_d[clr_idx_q] = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr0) mem_d[wa0] = wd0;
        if (wr1) mem_d[wa1] = wd1;
        conflict_d = wr0 && wr1 && same_addr;
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Reset holds the array so a same-cycle write is aborted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      conflict_q <= conflict_d;
      mem_q      <= mem_d;
    end
  end

  assign ready       = (state_q == RUN);
  assign wr_conflict = conflict_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    assign ra = rd_addr[k*AW +: AW];
    always_comb begin
      rv = mem_q[ra];
      if (BYPASS != 0 && we0 && wa0 == ra) rv = wd0;
      if (BYPASS != 0 && we1 && wa1 == ra) rv = wd1;
      if ((ZERO_REG != 0 && ra == '0) || state_q == CLEAR) rv = '0;
    end
    assign rd_data[k*XLEN +: XLEN] = rv;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp with a behavioural model; runs a
// bypassing and a non-bypassing instance from the same stimulus.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;

  logic                  clock;
  logic                  reset_n;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data, rd_data_nb;
  logic                  we0, we1, clear_req;
  logic [AW-1:0]         wa0, wa1;
  logic [XLEN-1:0]       wd0, wd1;
  logic                  ready, ready_nb;
  logic                  wr_conflict, wr_conflict_nb;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp dut (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr),
    .rd_data(rd_data), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .clear_req(clear_req),
    .ready(ready), .wr_conflict(wr_conflict)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .clear_req(clear_req),
    .ready(ready_nb), .wr_conflict(wr_conflict_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents become unobservable during a clear, so a
  // clear is modelled as "all zero now, busy for NREGS cycles".
  logic [XLEN-1:0] m_mem [NREGS];
  int              m_left  = NREGS;
  bit              m_conf  = 0;
  bit              m_valid = 0;

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a,
                                             input bit byp);
    if (m_left > 0) return '0;
    if (a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  // Inputs only change just after a rising edge, so values seen at the
  // falling edge are the ones the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        cmp("ready", {31'b0, ready}, {31'b0, m_left == 0});
        cmp("ready_nb", {31'b0, ready_nb}, {31'b0, m_left == 0});
        cmp("conflict", {31'b0, wr_conflict}, {31'b0, m_conf});
        cmp("conflict_nb", {31'b0, wr_conflict_nb}, {31'b0, m_conf});
        for (int k = 0; k < NREAD; k++) begin
          cmp("rd_data", rd_data[k*XLEN +: XLEN],
              exp_rd(rd_addr[k*AW +: AW], 1'b1));
          cmp("rd_data_nb", rd_data_nb[k*XLEN +: XLEN],
              exp_rd(rd_addr[k*AW +: AW], 1'b0));
        end
      end
      if (!reset_n) begin
        for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        m_left  = NREGS;
        m_conf  = 0;
        m_valid = 1;
      end else if (m_left > 0) begin
        m_left--;
        m_conf = 0;
      end else begin
        m_conf = we0 && we1 && wa0 == wa1 && wa0 != 0;
        if (we0 && wa0 != 0) m_mem[wa0] = wd0;
        if (we1 && wa1 != 0) m_mem[wa1] = wd1;
        if (clear_req) begin
          for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
          m_left = NREGS;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      mid();
      if (ready) break;
      cnt++;
      tick();
      we0 = 1'b0;
    end
    cmp(name, 32'(cnt), 32'd32);
  endtask

  initial begin
    reset_n = 1'b0; clear_req = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    rd_addr = '0;

    tick();
    mid();
    cmp("lit_reset_ready", {31'b0, ready}, 32'd0);
    cmp("lit_reset_conflict", {31'b0, wr_conflict}, 32'd0);
    tick();
    reset_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h5555_5555;
    count_busy("lit_reset_clear_len");
    tick();
    rd_addr = {5'd0, 5'd5};
    mid();
    cmp("lit_dropped_write", rd_data[31:0], 32'h0);

    tick();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD_BEEF;
    tick();
    we0 = 1'b0;
    rd_addr = {5'd0, 5'd3};
    mid();
    cmp("lit_basic_rd0", rd_data[31:0], 32'hDEAD_BEEF);
    cmp("lit_basic_rd1_zero", rd_data[63:32], 32'h0);

    tick();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222_2222;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    rd_addr = {5'd0, 5'd7};
    mid();
    cmp("lit_dual_data", rd_data[31:0], 32'h2222_2222);
    cmp("lit_dual_conflict", {31'b0, wr_conflict}, 32'd1);
    tick();
    mid();
    cmp("lit_dual_conflict_end", {31'b0, wr_conflict}, 32'd0);
    tick();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h2222_2222;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    rd_addr = {5'd0, 5'd0};
    mid();
    cmp("lit_zero_conflict", {31'b0, wr_conflict}, 32'd0);
    cmp("lit_zero_data", rd_data[31:0], 32'h0);

    tick();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA;
    tick();
    wd0 = 32'hB;
    rd_addr = {5'd0, 5'd9};
    mid();
    cmp("lit_bypass", rd_data[31:0], 32'hB);
    cmp("lit_nobypass_old", rd_data_nb[31:0], 32'hA);
    tick();
    we0 = 1'b0;
    mid();
    cmp("lit_nobypass_new", rd_data_nb[31:0], 32'hB);

    for (int i = 1; i < NREGS; i++) begin
      tick();
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i);
      rd_addr = {5'(i - 1), 5'(i)};
    end
    tick();
    we0 = 1'b0;
    rd_addr = {5'd31, 5'd17};
    mid();
    cmp("lit_loaded_17", rd_data[31:0], 32'd17);
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    count_busy("lit_runtime_clear_len");
    for (int i = 0; i < NREGS; i += 2) begin
      tick();
      rd_addr = {5'(i + 1), 5'(i)};
    end
    mid();
    cmp("lit_cleared_31", rd_data[63:32], 32'h0);

    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    count_busy("lit_reset_midclear_len");

    for (int n = 0; n < 2500; n++) begin
      tick();
      reset_n   = ($urandom_range(0, 299) != 0);
      clear_req = ($urandom_range(0, 99) == 0);
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      for (int k = 0; k < NREAD; k++) begin
        case ($urandom_range(0, 3))
          0: rd_addr[k*AW +: AW] = wa0;
          1: rd_addr[k*AW +: AW] = wa1;
          default: rd_addr[k*AW +: AW] = 5'($urandom);
        endcase
      end
    end
    tick();
    mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
